memory_write: RTL and testbench



---
 rtl/memory_write.sv | 68 ++++++
 tb/tb_memory_write.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/memory_write.sv
// Board-state memory for the 16x16 five-in-a-row game: 256 two-bit cells held in
// flip-flops, one write per clock edge, combinational single-cell read port.
// Optional occupancy protection: define MEMORY_WRITE_PROTECT_EN.
module memory_write #(
   parameter int CELLS  = 256,
   parameter int CELL_W = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CELL_W-1:0]         in,
   input  logic [7:0]                select,
   output logic [CELLS*CELL_W-1:0]   out,
   input  logic [7:0]                rd_select,
   output logic [CELL_W-1:0]         rd_data,
   output logic                      wr_reject
);

   logic [CELL_W-1:0] cur_cell;
   logic              wr_accept;

   // Bit offset of a cell is index*2, formed by appending a zero bit.
   assign cur_cell = out[{select, 1'b0} +: CELL_W];
   assign rd_data  = out[{rd_select, 1'b0} +: CELL_W];

`ifdef MEMORY_WRITE_PROTECT_EN
   logic wr_reject_reg;

   // Clearing is always allowed; placing a stone only onto an empty cell.
   assign wr_accept = (in == '0) || (cur_cell == '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_reject_reg <= 1'b0;
      end else begin
         wr_reject_reg <= ~wr_accept;
      end
   end

   assign wr_reject = wr_reject_reg;
`else
   logic unused_cur;

   assign wr_accept  = 1'b1;
   assign wr_reject  = 1'b0;
   assign unused_cur = ^cur_cell;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < CELLS; gi = gi + 1) begin : g_cell
         logic [CELL_W-1:0] cell_reg;
         logic              wr_hit;

         assign wr_hit = wr_accept && (select == 8'(gi));

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               cell_reg <= '0;
            end else if (wr_hit) begin
               cell_reg <= in;
            end
         end

         assign out[gi*CELL_W +: CELL_W] = cell_reg;
      end
   endgenerate

endmodule

// File: tb/tb_memory_write.sv
// Self-checking bench for memory_write: an array model of the board is updated
// on every strobe and the full board, read port and reject flag are compared to it.
module tb_memory_write;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [1:0]   in_code = 2'b00;
   logic [7:0]   select = 8'h00;
   logic [7:0]   rd_select = 8'h00;
   logic [511:0] out;
   logic [1:0]   rd_data;
   logic         wr_reject;

   memory_write dut (
      .clock     (clock),
      .reset     (reset),
      .in        (in_code),
      .select    (select),
      .out       (out),
      .rd_select (rd_select),
      .rd_data   (rd_data),
      .wr_reject (wr_reject)
   );

   int         checks = 0;
   int         errors = 0;
   logic [1:0] model_mem [256];
   logic       model_rej = 1'b0;

`ifdef MEMORY_WRITE_PROTECT_EN
   localparam bit PROTECT = 1'b1;
`else
   localparam bit PROTECT = 1'b0;
`endif

   function automatic logic [511:0] model_vec();
      logic [511:0] v;
      for (int i = 0; i < 256; i++) v[2*i +: 2] = model_mem[i];
      return v;
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) model_mem[i] = 2'b00;
      model_rej = 1'b0;
   endtask

   // Compare the whole visible state with the model.
   task automatic check_all(input string tag);
      logic [7:0] addrs [5];
      logic [7:0] keep;
      keep = rd_select;
      addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
      addrs[3] = select; addrs[4] = 8'($urandom_range(0, 255));
      chk({tag, " out"}, out, model_vec());
      chk({tag, " wr_reject"}, 512'(wr_reject), 512'(model_rej));
      foreach (addrs[k]) begin
         rd_select = addrs[k];
         #1;
         chk($sformatf("%s rd_data[%0h]", tag, addrs[k]), 512'(rd_data), 512'(model_mem[addrs[k]]));
      end
      rd_select = keep;
      #1;
      $display("txn %s: sel=%0h in=%0b rej=%0b", tag, select, in_code, wr_reject);
   endtask

   // One write strobe; the model applies the same rule the board must follow.
   task automatic strobe(input logic [1:0] code, input logic [7:0] sel);
      in_code = code;
      select  = sel;
      #2;
      clock = 1'b1;
      if (!reset) begin
         if (PROTECT && code != 2'b00 && model_mem[sel] != 2'b00) begin
            model_rej = 1'b1;
         end else begin
            model_mem[sel] = code;
            model_rej = 1'b0;
         end
      end
      #3;
      clock = 1'b0;
      #2;
   endtask

   initial begin
      model_clear();
      #3;
      reset = 1'b0;
      #2;
      check_all("reset");
      chk("lit reset out", out, 512'h0);

      // Single write at index 0, with old/new visible around the edge.
      rd_select = 8'h00;
      in_code = 2'b01; select = 8'h00;
      #1;
      chk("lit pre-edge rd", 512'(rd_data), 512'(2'b00));
      strobe(2'b01, 8'h00);
      chk("lit post-edge rd", 512'(rd_data), 512'(2'b01));
      chk("lit single out", out, 512'h1);
      check_all("w00");

      strobe(2'b10, 8'hFF);
      chk("lit corner", 512'(out[511:510]), 512'(2'b10));
      check_all("wFF");
      strobe(2'b01, 8'h12);
      chk("lit 0x12", 512'(out[39:34]), 512'(6'b000100));
      check_all("w12");

      // Regret: place and clear.
      strobe(2'b01, 8'h34);
      check_all("w34");
      strobe(2'b00, 8'h34);
      chk("lit regret", 512'(out[105:104]), 512'(2'b00));
      check_all("clr34");

      // Reserved code is stored verbatim.
      strobe(2'b11, 8'h80);
      check_all("w80");

      // Fill row 0 then reset asynchronously between edges.
      for (int i = 0; i < 16; i++) strobe(2'b10, 8'(i));
      check_all("row0");
      reset = 1'b1;
      #1;
      model_clear();
      chk("lit async reset", out, 512'h0);
      strobe(2'b01, 8'h05);
      check_all("edge in reset");
      reset = 1'b0;
      #2;
      check_all("reset release");

      // Occupied-cell overwrite behaviour.
      strobe(2'b01, 8'h55);
      check_all("w55 a");
      strobe(2'b10, 8'h55);
      check_all("w55 b");
`ifdef MEMORY_WRITE_PROTECT_EN
      chk("lit protect keep", 512'(out[171:170]), 512'(2'b01));
      chk("lit protect rej", 512'(wr_reject), 512'(1'b1));
`else
      chk("lit overwrite", 512'(out[171:170]), 512'(2'b10));
      chk("lit no rej", 512'(wr_reject), 512'(1'b0));
`endif
      strobe(2'b00, 8'h55);
      chk("lit clear 55", 512'(out[171:170]), 512'(2'b00));
      chk("lit rej low", 512'(wr_reject), 512'(1'b0));
      check_all("clr55");

      // Random writes across the board.
      for (int i = 0; i < 40; i++) begin
         strobe(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
         check_all("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
